capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Run-level sequencer for the capture/FIFO datapath.
- Takes host start/abort commands and drives the capture block's arm/abort strobes.
- Tracks armed → triggered → done progress, then watches the DMA stream until the capture buffer has drained.
- Reports status, error flags, beat count and a completion interrupt to the register/interrupt logic.

Parameters:
- saddr_w, 24, width of sample address/count values (buffer_size, beat_count)
- timeout_w, 32, width of the trigger-wait timeout counter

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- cmd_start  input  1  one-cycle start request
- cmd_abort  input  1  one-cycle abort request
- cfg_timeout  input  timeout_w  max cycles in WAIT_TRIG; 0 = no timeout
- buffer_size  input  saddr_w  expected number of DMA beats per run
- cap_arm  output  1  arm strobe to capture block
- cap_abort  output  1  abort strobe to capture block
- cap_ready  input  1  capture block idle/ready
- cap_armed  input  1  capture block armed
- cap_triggered  input  1  trigger fired
- cap_done  input  1  post-trigger capture complete
- dma_valid  input  1  DMA stream valid (monitor only)
- dma_ready  input  1  DMA stream ready (monitor only)
- dma_last  input  1  DMA stream last (monitor only)
- busy  output  1  high in any state except IDLE
- state  output  3  current state encoding
- beat_count  output  saddr_w  DMA beats seen in current run
- err_timeout  output  1  sticky: last run aborted by timeout
- err_length  output  1  sticky: last run drained with beat_count ≠ buffer_size
- err_user  output  1  sticky: last run aborted by cmd_abort
- irq  output  1  one-cycle pulse at end of every run (normal or aborted)

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE.
  - All outputs 0: cap_arm, cap_abort, busy, irq, beat_count, err_*.
  - Reset mid-run returns to IDLE immediately; no abort strobe is issued.
- State encodings: IDLE=0, ARM=1, WAIT_ARMED=2, WAIT_TRIG=3, WAIT_DONE=4, DRAIN=5, ABORT=6, COMPLETE=7.
- All outputs are registered; cap_arm/cap_abort/irq are asserted in the cycle the FSM is in the corresponding state.
- IDLE:
  - If cmd_start=1, cmd_abort=0 and cap_ready=1, go to ARM.
  - On that transition: clear beat_count and all err_* flags, and load the timeout counter with cfg_timeout.
  - cmd_start while cap_ready=0 is ignored.
  - cmd_abort in IDLE is ignored.
- ARM: cap_arm=1 for exactly one cycle → WAIT_ARMED.
- WAIT_ARMED: cap_armed=1 → WAIT_TRIG.
- WAIT_TRIG:
  - cap_triggered=1 → WAIT_DONE.
  - Otherwise, if cfg_timeout≠0, decrement the counter each cycle.
  - The counter reaching 0 sets err_timeout and goes to ABORT, i.e. exactly cfg_timeout cycles are spent in WAIT_TRIG.
  - If cap_triggered and expiry occur in the same cycle, the trigger wins.
- WAIT_DONE: cap_done=1 → DRAIN.
- DRAIN:
  - Every dma_valid & dma_ready cycle increments beat_count, saturating at all-ones.
  - A beat with dma_last=1 → COMPLETE.
  - On that last beat, set err_length if (beat_count+1) ≠ buffer_size; the comparison is on saddr_w bits.
  - dma_last without a valid&ready handshake is ignored.
- cmd_abort in ARM, WAIT_ARMED, WAIT_TRIG, WAIT_DONE or DRAIN:
  - Set err_user and go to ABORT.
  - cmd_abort has priority over every other transition in the same cycle.
- ABORT:
  - cap_abort=1 in the first ABORT cycle only.
  - Then wait for cap_ready=1 → COMPLETE.
  - cmd_start and cmd_abort are ignored.
- COMPLETE: irq=1 for one cycle → IDLE. cmd_start is ignored.
- Counts and flags: beat_count and err_* hold their values until the next accepted start.
- busy=1 ⇔ state≠IDLE.

Test Plan:
- Normal run (buffer_size=128, cfg_timeout=0): start with cap_ready=1; cap_armed 2 cycles later, cap_triggered after 10, cap_done after 20; 128 DMA beats, last on beat 128.
  → cap_arm pulses once; state walks 1,2,3,4,5,7,0; beat_count=128; irq one cycle; err_*=0.
- Timeout (cfg_timeout=50): armed but never triggered.
  → exactly 50 cycles in WAIT_TRIG; cap_abort one cycle; ABORT until cap_ready; then irq; err_timeout=1.
- Short drain (buffer_size=128): dma_last on beat 100, with dma_ready toggling 50%.
  → beat_count=100; err_length=1; irq pulse.
- User abort: cmd_abort in WAIT_DONE; then cmd_start and cmd_abort in the same cycle in IDLE.
  → err_user=1, one cap_abort, irq. The simultaneous start/abort in IDLE does not start a run (state stays 0).
- Trigger/timeout collision (cfg_timeout=5): cap_triggered on the expiry cycle.
  → goes to WAIT_DONE; err_timeout=0.
- Reset mid-DRAIN at beat 40: assert reset=0 for one cycle.
  → next cycle state=0, beat_count=0, no cap_abort, no irq. cmd_start with cap_ready=0 afterwards is ignored.

Source files
------------

// File: rtl/capture_ctrl.sv
// Run-level sequencer for the capture/FIFO datapath: issues arm/abort strobes,
// follows capture progress, monitors the DMA drain and reports status and errors.
module capture_ctrl #(
    parameter int saddr_w   = 24,
    parameter int timeout_w = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic [timeout_w-1:0] cfg_timeout,
    input  logic [saddr_w-1:0]   buffer_size,
    output logic                 cap_arm,
    output logic                 cap_abort,
    input  logic                 cap_ready,
    input  logic                 cap_armed,
    input  logic                 cap_triggered,
    input  logic                 cap_done,
    input  logic                 dma_valid,
    input  logic                 dma_ready,
    input  logic                 dma_last,
    output logic                 busy,
    output logic [2:0]           state,
    output logic [saddr_w-1:0]   beat_count,
    output logic                 err_timeout,
    output logic                 err_length,
    output logic                 err_user,
    output logic                 irq
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARM        = 3'd1,
        S_WAIT_ARMED = 3'd2,
        S_WAIT_TRIG  = 3'd3,
        S_WAIT_DONE  = 3'd4,
        S_DRAIN      = 3'd5,
        S_ABORT      = 3'd6,
        S_COMPLETE   = 3'd7
    } state_t;

    localparam logic [saddr_w-1:0]   BEAT_ONE = 1;
    localparam logic [timeout_w-1:0] TMO_ONE  = 1;

    state_t                r_state;
    state_t                w_next;
    logic [timeout_w-1:0]  r_tmo;
    logic                  r_tmo_en;
    logic [saddr_w-1:0]    r_beat;
    logic [saddr_w-1:0]    w_beat_inc;
    logic                  r_err_timeout;
    logic                  r_err_length;
    logic                  r_err_user;
    logic                  r_cap_arm;
    logic                  r_cap_abort;
    logic                  r_irq;
    logic                  r_busy;
    logic                  w_hs;
    logic                  w_abortable;
    logic                  w_user_abort;
    logic                  w_expire;
    logic                  w_accept;

    assign w_hs         = dma_valid & dma_ready;
    assign w_abortable  = (r_state == S_ARM) || (r_state == S_WAIT_ARMED) ||
                          (r_state == S_WAIT_TRIG) || (r_state == S_WAIT_DONE) ||
                          (r_state == S_DRAIN);
    assign w_user_abort = cmd_abort & w_abortable;
    // Counter holds the cycles still allowed, so the last permitted cycle sees 1.
    assign w_expire     = (r_state == S_WAIT_TRIG) && r_tmo_en && !cap_triggered &&
                          (r_tmo == TMO_ONE);
    assign w_accept     = (r_state == S_IDLE) && (w_next == S_ARM);
    assign w_beat_inc   = r_beat + BEAT_ONE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (cmd_start && !cmd_abort && cap_ready) w_next = S_ARM;
            S_ARM:        w_next = S_WAIT_ARMED;
            S_WAIT_ARMED: if (cap_armed) w_next = S_WAIT_TRIG;
            S_WAIT_TRIG: begin
                if (cap_triggered)  w_next = S_WAIT_DONE;
                else if (w_expire)  w_next = S_ABORT;
            end
            S_WAIT_DONE:  if (cap_done) w_next = S_DRAIN;
            S_DRAIN:      if (w_hs && dma_last) w_next = S_COMPLETE;
            S_ABORT:      if (cap_ready) w_next = S_COMPLETE;
            S_COMPLETE:   w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
        if (w_user_abort) w_next = S_ABORT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_tmo         <= '0;
            r_tmo_en      <= 1'b0;
            r_beat        <= '0;
            r_err_timeout <= 1'b0;
            r_err_length  <= 1'b0;
            r_err_user    <= 1'b0;
            r_cap_arm     <= 1'b0;
            r_cap_abort   <= 1'b0;
            r_irq         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cap_arm   <= (w_next == S_ARM);
            r_cap_abort <= (w_next == S_ABORT) && (r_state != S_ABORT);
            r_irq       <= (w_next == S_COMPLETE);
            r_busy      <= (w_next != S_IDLE);

            if (w_accept) begin
                r_beat        <= '0;
                r_err_timeout <= 1'b0;
                r_err_length  <= 1'b0;
                r_err_user    <= 1'b0;
                r_tmo         <= cfg_timeout;
                r_tmo_en      <= (cfg_timeout != '0);
            end

            if ((r_state == S_WAIT_TRIG) && r_tmo_en && !cap_triggered)
                r_tmo <= r_tmo - TMO_ONE;

            if (w_user_abort)
                r_err_user <= 1'b1;
            else if (w_expire)
                r_err_timeout <= 1'b1;

            if ((r_state == S_DRAIN) && w_hs && !w_user_abort) begin
                if (r_beat != '1)
                    r_beat <= w_beat_inc;
                // Length check uses the wrapped saddr_w-bit increment.
                if (dma_last)
                    r_err_length <= (w_beat_inc != buffer_size);
            end
        end
    end

    assign state       = r_state;
    assign cap_arm     = r_cap_arm;
    assign cap_abort   = r_cap_abort;
    assign irq         = r_irq;
    assign busy        = r_busy;
    assign beat_count  = r_beat;
    assign err_timeout = r_err_timeout;
    assign err_length  = r_err_length;
    assign err_user    = r_err_user;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: randomized runs checked against a run-level model of
// expected state sequence, strobe counts, beat count and error flags.
module tb_capture_ctrl;

    localparam int SW = 8;
    localparam int TW = 32;
    localparam int SAT = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_start, cmd_abort;
    logic [TW-1:0] cfg_timeout;
    logic [SW-1:0] buffer_size;
    logic          cap_arm, cap_abort, cap_ready, cap_armed, cap_triggered, cap_done;
    logic          dma_valid, dma_ready, dma_last;
    logic          busy, err_timeout, err_length, err_user, irq;
    logic [2:0]    state;
    logic [SW-1:0] beat_count;

    always #5 clk = ~clk;

    capture_ctrl #(.saddr_w(SW), .timeout_w(TW)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_timeout(cfg_timeout), .buffer_size(buffer_size),
        .cap_arm(cap_arm), .cap_abort(cap_abort), .cap_ready(cap_ready),
        .cap_armed(cap_armed), .cap_triggered(cap_triggered), .cap_done(cap_done),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_last(dma_last),
        .busy(busy), .state(state), .beat_count(beat_count),
        .err_timeout(err_timeout), .err_length(err_length), .err_user(err_user),
        .irq(irq)
    );

    int n_checks = 0;
    int n_errors = 0;
    string cur = "init";

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0d expected %0d", cur, tag, obs, exp);
        end
    endtask

    // Passive monitor: only this block writes these totals.
    int arm_cnt = 0, abort_cnt = 0, irq_cnt = 0, trig_cyc = 0, bad_cnt = 0;
    int seq_q[$];
    int last_st = 0;
    always @(negedge clk) begin
        if (cap_arm)   arm_cnt++;
        if (cap_abort) abort_cnt++;
        if (irq)       irq_cnt++;
        if (state == 3'd3) trig_cyc++;
        if (reset === 1'b1) begin
            if (busy !== (state != 3'd0)) bad_cnt++;
            if (cap_arm && state != 3'd1)   bad_cnt++;
            if (cap_abort && state != 3'd6) bad_cnt++;
            if (irq && state != 3'd7)       bad_cnt++;
        end
        if (int'(state) != last_st) begin
            seq_q.push_back(int'(state));
            last_st = int'(state);
        end
    end

    int a0, ab0, i0, t0, b0, q0;
    int exp_q[$];

    task automatic snap();
        a0 = arm_cnt; ab0 = abort_cnt; i0 = irq_cnt; t0 = trig_cyc; b0 = bad_cnt;
        q0 = seq_q.size();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_start = 0; cmd_abort = 0; cap_ready = 1; cap_armed = 0;
        cap_triggered = 0; cap_done = 0; dma_valid = 0; dma_ready = 0; dma_last = 0;
    endtask

    task automatic wait_state(input int s, input int budget);
        int k = 0;
        while (int'(state) != s && k < budget) begin
            tick();
            k++;
        end
        check($sformatf("reach_st%0d", s), state, s);
    endtask

    // Model of a drained run: beat count saturates, length check wraps at SW bits.
    function automatic int exp_beats(input int n);
        return (n > SAT) ? SAT : n;
    endfunction
    function automatic bit exp_len_err(input int n, input int bs);
        return (((exp_beats(n - 1) + 1) & SAT) != bs);
    endfunction

    task automatic start_run(input int bs, input int tmo);
        snap();
        buffer_size = bs[SW-1:0];
        cfg_timeout = tmo;
        cap_ready = 1; cmd_start = 1;
        tick();
        cmd_start = 0; cap_ready = 0;
        check("arm_st", state, 1);
    endtask

    task automatic go_trig(input int dly);
        wait_state(2, 5);
        repeat (dly) tick();
        cap_armed = 1;
        tick();
        cap_armed = 0;
        check("trig_st", state, 3);
    endtask

    task automatic go_done(input int dly);
        repeat (dly) tick();
        cap_triggered = 1;
        tick();
        cap_triggered = 0;
        check("done_st", state, 4);
    endtask

    task automatic go_drain(input int dly);
        repeat (dly) tick();
        cap_done = 1;
        tick();
        cap_done = 0;
        check("drain_st", state, 5);
    endtask

    task automatic drain(input int n, input int pct, input bit with_last);
        int sent = 0;
        int guard = 0;
        bit hs;
        while (sent < n && guard < 20000) begin
            dma_valid = ($urandom_range(0, 9) != 0);
            dma_ready = ($urandom_range(0, 99) < pct);
            hs = dma_valid && dma_ready;
            dma_last = with_last && ((sent == n - 1) || (!hs && $urandom_range(0, 3) == 0));
            tick();
            if (hs) sent++;
            guard++;
        end
        dma_valid = 0; dma_ready = 0; dma_last = 0;
        check("beats_sent", sent, n);
    endtask

    task automatic finish_run(input int e_beat, input bit e_to, input bit e_len, input bit e_usr,
                              input int e_arm, input int e_abort, input int e_irq, input int e_trig);
        @(negedge clk);
        #1;
        check("beat_count", beat_count, e_beat);
        check("err_timeout", err_timeout, e_to);
        check("err_length", err_length, e_len);
        check("err_user", err_user, e_usr);
        check("arm_pulses", arm_cnt - a0, e_arm);
        check("abort_pulses", abort_cnt - ab0, e_abort);
        check("irq_pulses", irq_cnt - i0, e_irq);
        if (e_trig >= 0) check("trig_cycles", trig_cyc - t0, e_trig);
        check("busy_align", bad_cnt - b0, 0);
        check("seq_len", seq_q.size() - q0, exp_q.size());
        for (int i = 0; i < exp_q.size() && q0 + i < seq_q.size(); i++)
            check($sformatf("seq%0d", i), seq_q[q0 + i], exp_q[i]);
    endtask

    task automatic normal_run(input int bs, input int n, input int pct, input int tmo, input int tdly);
        start_run(bs, tmo);
        go_trig($urandom_range(0, 3));
        go_done(tdly);
        go_drain($urandom_range(0, 20));
        drain(n, pct, 1'b1);
        check("complete_st", state, 7);
        check("irq_hi", irq, 1);
        cmd_start = 1; cap_ready = 1;
        tick();
        cmd_start = 0;
        check("idle_after", state, 0);
        exp_q = '{1, 2, 3, 4, 5, 7, 0};
        finish_run(exp_beats(n), 0, exp_len_err(n, bs), 0, 1, 0, 1, tdly + 1);
    endtask

    task automatic finish_abort();
        cap_ready = 0;
        repeat ($urandom_range(1, 4)) tick();
        cmd_start = 1; cmd_abort = 1;
        tick();
        cmd_start = 0; cmd_abort = 0;
        check("abort_hold", state, 6);
        cap_ready = 1;
        tick();
        check("abort_exit", state, 7);
        tick();
        check("abort_idle", state, 0);
    endtask

    initial begin
        idle_inputs();
        cfg_timeout = 0; buffer_size = 0;
        reset = 0;
        repeat (3) tick();
        cur = "reset";
        check("state", state, 0);
        check("busy", busy, 0);
        check("cap_arm", cap_arm, 0);
        check("cap_abort", cap_abort, 0);
        check("irq", irq, 0);
        check("beat_count", beat_count, 0);
        check("errs", {err_timeout, err_length, err_user}, 0);
        reset = 1;
        cap_ready = 0; cmd_start = 1;
        tick();
        cmd_start = 0; cap_ready = 1;
        check("start_not_ready", state, 0);
        cmd_abort = 1;
        tick();
        cmd_abort = 0;
        check("abort_in_idle", state, 0);

        cur = "normal";
        normal_run(128, 128, 100, 0, 9);
        cur = "short";
        normal_run(128, 100, 50, 0, 3);
        cur = "saturate";
        normal_run(0, 300, 100, 0, 2);
        for (int r = 0; r < 5; r++) begin
            cur = $sformatf("rand%0d", r);
            normal_run($urandom_range(1, 255), $urandom_range(1, 300), $urandom_range(30, 100),
                       ($urandom_range(0, 1) != 0) ? 0 : 100, $urandom_range(0, 15));
        end

        for (int r = 0; r < 4; r++) begin
            int tmo;
            tmo = (r == 0) ? 50 : $urandom_range(1, 20);
            cur = $sformatf("timeout%0d", tmo);
            start_run(64, tmo);
            go_trig($urandom_range(0, 3));
            wait_state(6, tmo + 5);
            finish_abort();
            exp_q = '{1, 2, 3, 6, 7, 0};
            finish_run(0, 1, 0, 0, 1, 1, 1, tmo);
        end

        cur = "collision";
        start_run(16, 5);
        go_trig(1);
        repeat (4) tick();
        cap_triggered = 1;
        tick();
        cap_triggered = 0;
        check("collide_st", state, 4);
        go_drain(2);
        drain(16, 100, 1'b1);
        tick();
        tick();
        exp_q = '{1, 2, 3, 4, 5, 7, 0};
        finish_run(16, 0, 0, 0, 1, 0, 1, 5);

        for (int st = 1; st <= 5; st++) begin
            cur = $sformatf("uabort%0d", st);
            start_run(64, 0);
            if (st >= 2) wait_state(2, 5);
            if (st >= 3) go_trig($urandom_range(0, 2));
            if (st >= 4) go_done($urandom_range(0, 3));
            if (st >= 5) go_drain(1);
            cmd_abort = 1;
            cap_armed = (st == 2); cap_triggered = (st == 3); cap_done = (st == 4);
            tick();
            cmd_abort = 0; cap_armed = 0; cap_triggered = 0; cap_done = 0;
            check("abort_st", state, 6);
            finish_abort();
            exp_q.delete();
            for (int s = 1; s <= st; s++) exp_q.push_back(s);
            exp_q.push_back(6); exp_q.push_back(7); exp_q.push_back(0);
            finish_run(0, 0, 0, 1, 1, 1, 1, -1);
        end

        cur = "idle_start_abort";
        snap();
        cap_ready = 1; cmd_start = 1; cmd_abort = 1;
        tick();
        cmd_start = 0; cmd_abort = 0;
        tick();
        check("state", state, 0);
        exp_q.delete();
        finish_run(0, 0, 0, 1, 0, 0, 0, 0);

        cur = "reset_drain";
        start_run(128, 0);
        go_trig(1);
        go_done(2);
        go_drain(1);
        drain(40, 100, 1'b0);
        check("beats40", beat_count, 40);
        snap();
        reset = 0;
        tick();
        reset = 1;
        check("state", state, 0);
        check("busy", busy, 0);
        check("beat_count0", beat_count, 0);
        cap_ready = 0; cmd_start = 1;
        tick();
        cmd_start = 0;
        check("start_not_ready", state, 0);
        tick();
        exp_q = '{0};
        finish_run(0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
